// File: rtl/decodificador_secded_if.sv
// Handshake and status bundle for the SECDED decoder: codeword in, corrected word,
// syndrome, error class and error counters out.
interface decodificador_secded_if #(
    parameter int K     = 4,
    parameter int CNT_W = 16
);
    function automatic int calc_r(input int k);
        int r;
        r = 1;
        for (int i = 0; i < 7; i++)
            if ((1 << r) < k + r + 1) r = r + 1;
        return r;
    endfunction

    localparam int R = calc_r(K);
    localparam int N = K + R + 1;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_code;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     out_data;
    logic [R:0]       out_sindrome;
    logic [1:0]       out_estado;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_unc;

    modport master (
        output in_valid, in_code, out_ready, clr_cnt,
        input  in_ready, out_valid, out_data, out_sindrome, out_estado, cnt_corr, cnt_unc
    );

    modport slave (
        input  in_valid, in_code, out_ready, clr_cnt,
        output in_ready, out_valid, out_data, out_sindrome, out_estado, cnt_corr, cnt_unc
    );
endinterface

// File: rtl/decodificador_secded.sv
// Two-stage pipelined SECDED (extended Hamming) decoder with valid/ready flow control.
// Error counters are built only when SECDED_CONTADORES_EN is defined; otherwise they read 0.
module decodificador_secded #(
    parameter int K     = 4,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    decodificador_secded_if.slave bus
);
    function automatic int calc_r(input int k);
        int r;
        r = 1;
        for (int i = 0; i < 7; i++)
            if ((1 << r) < k + r + 1) r = r + 1;
        return r;
    endfunction

    localparam int R = calc_r(K);
    localparam int N = K + R + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic         take_p2;
    logic         acc;
    logic         xfer;
    logic         vld_p1;
    logic [N-1:0] code_p1;
    logic [R-1:0] sind_c;
    logic         par_c;
    logic [N-1:0] fix_c;
    logic [K-1:0] data_c;
    logic [1:0]   estado_c;
    logic         vld_p2;
    logic [K-1:0] data_p2;
    logic [R:0]   sind_p2;
    logic [1:0]   estado_p2;

    assign take_p2      = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || take_p2;
    assign acc          = bus.in_valid && bus.in_ready;
    assign xfer         = vld_p2 && bus.out_ready;

    // Stage 1: received codeword
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               vld_p1 <= 1'b0;
        else if (bus.in_ready) vld_p1 <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (acc) code_p1 <= bus.in_code;
    end

    always_comb begin
        sind_c = '0;
        par_c  = ^code_p1;
        for (int p = 1; p < N; p++)
            for (int j = 0; j < R; j++)
                if (((p >> j) & 1) == 1) sind_c[j] = sind_c[j] ^ code_p1[p-1];

        if (sind_c == '0)                           estado_c = par_c ? 2'b10 : 2'b00;
        else if (par_c && (int'(sind_c) <= K + R)) estado_c = 2'b01;
        else                                        estado_c = 2'b11;

        fix_c = code_p1;
        for (int p = 1; p < N; p++)
            if (estado_c == 2'b01 && int'(sind_c) == p) fix_c[p-1] = !code_p1[p-1];

        // Data bits are shifted in from the top so the lowest position lands in bit 0
        data_c = '0;
        for (int p = 1; p < N; p++)
            if ((p & (p - 1)) != 0) data_c = (data_c >> 1) | (K'(fix_c[p-1]) << (K - 1));
    end

    // Stage 2: decoded result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            sind_p2   <= '0;
            estado_p2 <= 2'b00;
        end else if (take_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2   <= data_c;
                sind_p2   <= {par_c, sind_c};
                estado_p2 <= estado_c;
            end
        end
    end

    assign bus.out_valid    = vld_p2;
    assign bus.out_data     = data_p2;
    assign bus.out_sindrome = sind_p2;
    assign bus.out_estado   = estado_p2;

`ifdef SECDED_CONTADORES_EN
    logic [CNT_W-1:0] cnt_corr_q;
    logic [CNT_W-1:0] cnt_unc_q;

    // Clear takes priority over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else if (bus.clr_cnt) begin
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else if (xfer) begin
            if (estado_p2 == 2'b01 || estado_p2 == 2'b10) cnt_corr_q <= sat_inc(cnt_corr_q);
            else if (estado_p2 == 2'b11)                  cnt_unc_q  <= sat_inc(cnt_unc_q);
        end
    end

    assign bus.cnt_corr = cnt_corr_q;
    assign bus.cnt_unc  = cnt_unc_q;
`else
    assign bus.cnt_corr = '0;
    assign bus.cnt_unc  = '0;
`endif
endmodule

// File: doc/decodificador_secded.md
# decodificador_secded

Parametrised, pipelined SECDED (extended Hamming) decoder. It accepts a received codeword over a valid/ready handshake, computes the Hamming syndrome and the global parity check, and corrects any single-bit error. It flags double errors and emits the decoded data word with its syndrome and an error class. It sits between the switch/receive path and the display path, and replaces the fixed 8-bit syndrome detector with a K-bit generalisation plus error statistics.

## Interface
- `K`, default 4: data bits; legal range 1..57.
- `R`, derived (not overridable): smallest R with 2^R >= K+R+1.
- `N`, derived: K+R+1, the full codeword width.
- `CNT_W`, default 16: width of each error counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: `in_code` is valid.
- `in_ready`, out, 1: decoder can accept a word this cycle.
- `in_code`, in, N: received word. Bit i (i < N-1) is Hamming position i+1, and bit N-1 is the overall parity bit.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, K: corrected data. Data bits fill the non-power-of-two positions in ascending order, LSB first.
- `out_sindrome`, out, R+1: `{g, s[R-1:0]}`.
- `out_estado`, out, 2: error class.
- `clr_cnt`, in, 1: synchronous clear of the counters.
- `cnt_corr`, out, CNT_W: corrected-error count.
- `cnt_unc`, out, CNT_W: uncorrectable-error count.

## Operation
- Syndrome: s[j] = XOR of `in_code` bits whose position has bit j set. g = XOR of all N bits; g = 0 means even parity, which is correct.
- Classification (`out_estado`):
  - s=0, g=0 → 00: no error.
  - s≠0, g=1, s ≤ K+R → 01: flip position s; data corrected.
  - s=0, g=1 → 10: overall parity bit wrong; data unaffected.
  - s≠0, g=0, or s > K+R → 11: uncorrectable. `out_data` carries the raw data bits, uncorrected.
- Pipeline stage 1 registers `in_code` on accept (`in_valid && in_ready`).
- Pipeline stage 2 registers the data, syndrome and class computed from stage 1.
- Ready chain, fully combinational:
  - stage 2 can take a word when `!v2 || out_ready`.
  - `in_ready = !v1 || (stage 2 can take)`.
- No bubbles are inserted. No word is dropped or duplicated under backpressure.
- Outputs hold stable while `out_valid && !out_ready`.
- Counters increment only on an output transfer (`out_valid && out_ready`):
  - `cnt_corr` increments on class 01 or 10.
  - `cnt_unc` increments on class 11.
  - Both saturate at 2^CNT_W−1.
  - `clr_cnt` beats an increment in the same cycle; the counter reads 0 afterwards.

## Timing
- Reset values: `v1`=`v2`=0, `out_valid`=0, `out_data`=0, `out_sindrome`=0, `out_estado`=00, counters 0. `in_ready` is 1 once reset is released.
- Latency: a word accepted in cycle n appears with `out_valid`=1 in cycle n+2, provided `out_ready` was held high.
- Throughput: 1 word/cycle sustained.
- Stall: with `out_ready` low, two words are buffered (stages 1 and 2), then `in_ready`=0.
  - The first cycle with `out_ready`=1 transfers the stage-2 word.
  - In that same cycle `in_ready` returns to 1, so a simultaneous accept is legal.
- Reset mid-operation: in-flight words are discarded without being reported, and counters are zeroed asynchronously.
- `in_code` is ignored when `in_valid`=0. The stage registers are not required to clear.

## Configuration
- `SECDED_CONTADORES_EN` defined: `cnt_corr`, `cnt_unc` and `clr_cnt` behave as above.
- Undefined: the counter logic is compiled out. `cnt_corr` and `cnt_unc` are tied to 0, `clr_cnt` is ignored, and the ports remain present.

## Test plan
All scenarios use K=4, so N=8 and data 4'hB encodes to 8'h55.
- Clean word: `in_code`=8'h55 → `out_data`=4'hB, `out_sindrome`=4'h0, `out_estado`=00, at cycle n+2.
- Single data error: 8'h45 (bit 4 flipped) → `out_data`=4'hB, `out_sindrome`=4'hD, `out_estado`=01, `cnt_corr`=1.
- Overall-parity error: 8'hD5 → `out_data`=4'hB, `out_sindrome`=4'h8, `out_estado`=10, `cnt_corr` increments.
- Double error: 8'h56 → `out_sindrome`=4'h3, `out_estado`=11, `out_data`=4'hB (raw data bits unaffected), `cnt_unc`=1.
- Backpressure:
  - Stimulus: `out_ready`=0; offer 8'h55, 8'h45 and 8'h56 back-to-back.
  - Required: `in_ready` drops after 2 accepts; the third word is held.
  - Then set `out_ready`=1: all three words emerge in order with no loss or duplication, one per cycle.
- Saturation and clear (CNT_W=2):
  - Stimulus: five 8'h45 transfers.
  - Required: `cnt_corr` holds at 3.
  - Then assert `clr_cnt` in the same cycle as a transfer: the counter reads 0.
  - Then assert `rst` mid-stream: `out_valid` goes to 0 immediately.
